shift_frame_ctrl: RTL and testbench
===================================

// Module: shift_frame_ctrl
// PURPOSE
//   Sequencer for an N-bit serial shift register (right-shift, LSB-first): accepts a
//   parallel word over a valid/ready handshake, shifts it out serially one bit per
//   bit-period while shifting serial_in into the same register, then presents the
//   captured word. Sits between parallel producer/consumer logic and a serial link.
// PARAMETERS
//   N    8  data word width in bits (>=2)
//   DIV  4  clock cycles per bit period (>=1); DIV=1 shifts every cycle
// PORTS
//   clk            in   1      rising-edge clock, single clock domain
//   reset          in   1      asynchronous, active-low (0 = reset), async assert
//   tx_data        in   N      parallel word to send
//   tx_valid       in   1      tx_data valid
//   tx_ready       out  1      controller can accept a word
//   serial_in      in   1      serial receive bit, sampled at each shift
//   serial_out     out  1      serial transmit bit (register LSB)
//   busy           out  1      frame in progress
//   rx_data        out  N      last captured word (held until next frame ends)
//   rx_valid       out  1      one-cycle pulse: rx_data updated
//   rx_parity_err  out  1      parity mismatch, qualified by rx_valid
// BEHAVIOUR
//   - Reset (reset=0): state IDLE; shift reg, bit_cnt, div_cnt, rx_data = 0;
//     tx_ready=0 while reset low, 1 from first clock after release;
//     serial_out=0, busy=0, rx_valid=0, rx_parity_err=0.
//   - States: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: tx_ready=1, busy=0, serial_out=0. On tx_valid&&tx_ready at edge k:
//     sr<=tx_data, bit_cnt<=0, div_cnt<=0, go SHIFT. tx_valid without ready ignored.
//   - SHIFT: tx_ready=0, busy=1, serial_out=sr[0] (registered, bit 0 visible from k+1).
//     div_cnt counts 0..DIV-1; at div_cnt==DIV-1: sr<={serial_in,sr[N-1:1]},
//     bit_cnt++, div_cnt<=0. serial_in sampled only on that last cycle of a bit.
//     After F shifts (F=N, or N+1 with parity) go DONE. SHIFT lasts exactly F*DIV cycles.
//   - DONE (1 cycle): rx_data<=captured word, rx_valid=1 that cycle, busy=1,
//     tx_ready=0; next cycle IDLE. Min frame-to-frame spacing: F*DIV+2 cycles.
//   - rx_valid is a single-cycle pulse, never back-to-back.
//   - Counters: bit_cnt width $clog2(N+2), div_cnt width $clog2(DIV+1); no wrap beyond
//     terminal values; DIV=1 keeps div_cnt at 0.
//   - tx_data/tx_valid changes during SHIFT/DONE have no effect.
//   - Reset mid-frame: immediate abort, all state/outputs to reset values,
//     no rx_valid for the aborted frame; rx_data cleared to 0.
// CONFIGURATION
//   SHIFT_PARITY_EN defined: frame is N+1 bits; after the N data bits serial_out
//     carries even parity ^tx_data (latched at accept). The (N+1)th bit received
//     is parity; rx_parity_err = (^rx_word) ^ rx_parity_bit, valid with rx_valid,
//     0 otherwise. Register is N+1 bits wide internally.
//   SHIFT_PARITY_EN undefined: frame is N bits, rx_parity_err tied 0, no parity
//     logic instantiated.
// TESTING (N=8, DIV=2 unless noted)
//   1 Reset: hold reset=0 with tx_valid=1 -> tx_ready=0, serial_out=0, rx_data=0;
//     release -> tx_ready=1 next cycle, no frame started before it.
//   2 Loopback serial_out->serial_in, tx_data=8'hA5 -> serial_out 1,0,1,0,0,1,0,1
//     each 2 cycles; SHIFT 16 cycles; rx_valid one pulse, rx_data=8'hA5.
//   3 serial_in held 1, tx_data=8'h00 -> serial_out all 0, rx_data=8'hFF; DIV=1
//     repeat -> SHIFT exactly 8 cycles.
//   4 tx_valid held high continuously -> frames back-to-back with F*DIV+2 spacing,
//     tx_ready only in IDLE, exactly one rx_valid per frame.
//   5 Drop reset after 3 shifted bits -> busy=0, no rx_valid, rx_data=0; new
//     frame after release completes normally.
//   6 SHIFT_PARITY_EN, loopback, tx_data=8'h07 -> 9th bit=1, rx_parity_err=0;
//     force serial_in=0 on bit 9 -> rx_parity_err=1 with rx_valid.

Source files
------------

// File: rtl/shift_frame_ctrl.sv
// Purpose: serial shift-frame sequencer; loads a parallel word, shifts it out LSB-first while capturing serial_in.
// Latency: accept to rx_valid is F*DIV+1 cycles (F = N, or N+1 with parity); next accept F*DIV+2 cycles after the previous one.
// Backpressure: tx_ready is high only in IDLE (and not before the first clock after reset); tx input is ignored while a frame runs.
// Optional feature macro: SHIFT_PARITY_EN appends an even-parity bit to each frame and checks it on receive.
module shift_frame_ctrl #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  input  logic         serial_in,
  output logic         serial_out,
  output logic         busy,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         rx_parity_err
);

`ifdef SHIFT_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif
  localparam int BW = $clog2(N + 2);
  localparam int DW = $clog2(DIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(F - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic            ready_en_q;
  logic [F-1:0]    sr_q;
  logic [BW-1:0]   bit_cnt_q;
  logic [DW-1:0]   div_cnt_q;
  logic            accept;
  logic            bit_end;
  logic            frame_end;
  logic [F-1:0]    sr_shift;
  logic [F-1:0]    sr_load;

  // The register is one frame wide, so after F shifts the received frame sits in it LSB-aligned.
  assign sr_shift  = {serial_in, sr_q[F-1:1]};
  assign bit_end   = (state_q == SHIFT) && (div_cnt_q == DIV_LAST);
  assign frame_end = bit_end && (bit_cnt_q == BIT_LAST);

`ifdef SHIFT_PARITY_EN
  // Parity is latched into the top bit at accept so it goes out right after the data bits.
  assign sr_load = {^tx_data, tx_data};
`else
  assign sr_load = tx_data;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    tx_ready   = 1'b0;
    busy       = 1'b0;
    rx_valid   = 1'b0;
    serial_out = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_ready = ready_en_q;
        accept   = tx_valid && ready_en_q;
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        serial_out = sr_q[0];
        if (frame_end) state_d = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        rx_valid = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit/divider counters and captured word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_q <= 1'b0;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      rx_data    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) begin
        sr_q      <= sr_load;
        bit_cnt_q <= '0;
        div_cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        if (bit_end) begin
          sr_q      <= sr_shift;
          bit_cnt_q <= bit_cnt_q + BW'(1);
          div_cnt_q <= '0;
        end else begin
          div_cnt_q <= div_cnt_q + DW'(1);
        end
      end
      // Capture on the final shift edge so rx_data is already valid during DONE.
      if (frame_end) rx_data <= sr_shift[N-1:0];
    end
  end

`ifdef SHIFT_PARITY_EN
  logic rx_perr_q;

  // Parity check result for the frame being completed, exposed only alongside rx_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         rx_perr_q <= 1'b0;
    else if (frame_end) rx_perr_q <= (^sr_shift[N-1:0]) ^ sr_shift[N];
  end

  assign rx_parity_err = rx_valid & rx_perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Testbench for shift_frame_ctrl: N=8 with DIV=2 (main instance) and DIV=1 (second instance).
// Reference model: expected line bits are the word's bits LSB-first each held DIV cycles;
// expected rx word is assembled from serial_in values present on the last cycle of each bit.
module tb_shift_frame_ctrl;
  localparam int N   = 8;
  localparam int DIV = 2;
`ifdef SHIFT_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         serial_in = 1'b0;
  logic         serial_out;
  logic         busy;
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic         rx_parity_err;

  logic [N-1:0] tx_data1 = '0;
  logic         tx_valid1 = 1'b0;
  logic         tx_ready1;
  logic         serial_in1 = 1'b0;
  logic         serial_out1;
  logic         busy1;
  logic [N-1:0] rx_data1;
  logic         rx_valid1;
  logic         rx_parity_err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_frame_ctrl #(.N(N), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .serial_in(serial_in), .serial_out(serial_out), .busy(busy), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_parity_err(rx_parity_err)
  );

  shift_frame_ctrl #(.N(N), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .serial_in(serial_in1), .serial_out(serial_out1), .busy(busy1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .rx_parity_err(rx_parity_err1)
  );

  // One full frame on the DIV=2 instance, starting from IDLE.
  // si_mode: 0 loopback, 1 random, 2 constant 1, 3 loopback with the last frame bit forced 0.
  // hold: keep tx_valid high throughout so the next frame is accepted as soon as possible.
  task automatic run_frame(input logic [N-1:0] data, input int si_mode, input bit hold);
    logic [F-1:0] exp_bits;
    logic [F-1:0] got_bits;
    logic         exp_perr;
    int           b;
    for (int i = 0; i < N; i++) exp_bits[i] = data[i];
`ifdef SHIFT_PARITY_EN
    exp_bits[N] = ^data;
`endif
    got_bits = '0;
    @(negedge clk);
    checks++;
    if ({tx_ready, busy, rx_valid, serial_out} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_state: ready/busy/rxv/sout=%b required 1000", {tx_ready, busy, rx_valid, serial_out});
    end
    tx_data  = data;
    tx_valid = 1'b1;
    for (int c = 0; c < F * DIV; c++) begin
      @(negedge clk);
      tx_valid = hold ? 1'b1 : 1'b0;
      tx_data  = N'($urandom);
      b = c / DIV;
      checks++;
      if ({busy, tx_ready, rx_valid, serial_out} !== {3'b100, exp_bits[b]}) begin
        errors++;
        $display("FAIL shift_cycle %0d: busy/ready/rxv/sout=%b required %b", c,
                 {busy, tx_ready, rx_valid, serial_out}, {3'b100, exp_bits[b]});
      end
      case (si_mode)
        0:       serial_in = serial_out;
        1:       serial_in = 1'($urandom);
        2:       serial_in = 1'b1;
        default: serial_in = (b == F - 1) ? 1'b0 : serial_out;
      endcase
      if (c % DIV == DIV - 1) got_bits[b] = serial_in;
    end
`ifdef SHIFT_PARITY_EN
    exp_perr = (^got_bits[N-1:0]) ^ got_bits[N];
`else
    exp_perr = 1'b0;
`endif
    @(negedge clk);
    checks++;
    if ({rx_valid, busy, tx_ready} !== 3'b110) begin
      errors++;
      $display("FAIL done_state: rxv/busy/ready=%b required 110", {rx_valid, busy, tx_ready});
    end
    checks++;
    if (rx_data !== got_bits[N-1:0]) begin
      errors++;
      $display("FAIL rx_data: got %h required %h", rx_data, got_bits[N-1:0]);
    end
    checks++;
    if (rx_parity_err !== exp_perr) begin
      errors++;
      $display("FAIL rx_parity_err: got %b required %b", rx_parity_err, exp_perr);
    end
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, serial_out, busy, rx_valid, rx_parity_err, rx_data} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready/sout/busy/rxv/perr=%b rx_data=%h required all 0",
               {tx_ready, serial_out, busy, rx_valid, rx_parity_err}, rx_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_at_release: got %b required 0", tx_ready);
    end
    @(negedge clk);
    checks++;
    if ({tx_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL ready_after_first_clk: ready/busy=%b required 10", {tx_ready, busy});
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_loopback();
    run_frame(8'hA5, 0, 1'b0);
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL loopback_word: got %h required a5", rx_data);
    end
  endtask

  task automatic test_serial_ones();
    run_frame(8'h00, 2, 1'b0);
    checks++;
    if (rx_data !== 8'hFF) begin
      errors++;
      $display("FAIL ones_word: got %h required ff", rx_data);
    end
  endtask

  task automatic test_div1();
    int cyc = 0;
    @(negedge clk);
    checks++;
    if (tx_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL div1_ready: got %b required 1", tx_ready1);
    end
    tx_data1   = 8'h00;
    serial_in1 = 1'b1;
    tx_valid1  = 1'b1;
    @(negedge clk);
    tx_valid1 = 1'b0;
    while (busy1 && !rx_valid1 && cyc < 100) begin
      checks++;
      if (serial_out1 !== 1'b0) begin
        errors++;
        $display("FAIL div1_sout cycle %0d: got %b required 0", cyc, serial_out1);
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != F) begin
      errors++;
      $display("FAIL div1_shift_len: got %0d cycles required %0d", cyc, F);
    end
    checks++;
    if ({rx_valid1, rx_data1} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL div1_done: rxv=%b rx_data=%h required 1 ff", rx_valid1, rx_data1);
    end
    @(negedge clk);
    checks++;
    if ({rx_valid1, busy1, tx_ready1} !== 3'b001) begin
      errors++;
      $display("FAIL div1_idle: rxv/busy/ready=%b required 001", {rx_valid1, busy1, tx_ready1});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_frame(N'($urandom), 1, i < 3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_frame(N'($urandom), 1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(8'h3C, 0, 1'b0);
    @(negedge clk);
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, rx_valid, tx_ready, serial_out, rx_data} !== 12'd0) begin
      errors++;
      $display("FAIL abort_outputs: busy/rxv/ready/sout=%b rx_data=%h required all 0",
               {busy, rx_valid, tx_ready, serial_out}, rx_data);
    end
    @(negedge clk);
    checks++;
    if ({busy, rx_valid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_rx_valid: busy/rxv=%b required 00", {busy, rx_valid});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_ready, busy, rx_valid} !== 3'b100) begin
      errors++;
      $display("FAIL abort_recover: ready/busy/rxv=%b required 100", {tx_ready, busy, rx_valid});
    end
    run_frame(8'h5A, 0, 1'b0);
  endtask

`ifdef SHIFT_PARITY_EN
  task automatic test_parity();
    run_frame(8'h07, 0, 1'b0);
    checks++;
    if (rx_parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_good: got %b required 0", rx_parity_err);
    end
    run_frame(8'h07, 3, 1'b0);
    checks++;
    if ({rx_valid, rx_parity_err} !== 2'b11) begin
      errors++;
      $display("FAIL parity_bad: rxv/perr=%b required 11", {rx_valid, rx_parity_err});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_serial_ones();
    test_div1();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
`ifdef SHIFT_PARITY_EN
    test_parity();
`endif
    @(negedge clk);
    checks++;
    if ({rx_valid, busy, tx_ready} !== 3'b001) begin
      errors++;
      $display("FAIL final_idle: rxv/busy/ready=%b required 001", {rx_valid, busy, tx_ready});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
